passcode_controller: RTL
========================

# passcode_controller

Sequencer for the OLED passcode screen. It decides when the passcode glyphs are shown and whether they are inverted, which replaces the raw `micD`/`sw0` drive of the display block. It also runs a 4-digit BCD entry state machine from debounced button pulses, compares the entry against a stored code, and applies a retry limit with an optional timed lockout. It sits between the button/mic front end and the passcode display.

## Interface
- `CODE`, 16'h2026: expected passcode, 4 BCD digits, digit 0 in [15:12].
- `MAX_TRIES`, 3: consecutive failed checks before lockout (1..15).
- `SHOW_CYC`, 100_000_000: cycles the passcode screen is shown after a mic trigger.
- `LOCKOUT_CYC`, 500_000_000: lockout duration in cycles.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mic_trig`  in  1  single-cycle pulse, mic threshold crossed.
- `btn_up`  in  1  single-cycle pulse, increment current digit.
- `btn_down`  in  1  single-cycle pulse, decrement current digit.
- `btn_next`  in  1  single-cycle pulse, confirm digit / skip show.
- `lock`  in  1  single-cycle pulse, relock from UNLOCKED.
- `show_code`  out  1  drives display `micD`.
- `invert`  out  1  drives display `sw0`.
- `unlocked`  out  1  high in UNLOCKED.
- `lockout`  out  1  high in LOCKOUT.
- `digit_idx`  out  2  digit being edited.
- `digit_val`  out  4  BCD value of the digit being edited.
- `fail_cnt`  out  4  consecutive failed checks.

## Operation
- States: LOCKED, SHOW, ENTRY, CHECK, UNLOCKED, LOCKOUT. Reset enters LOCKED.
- LOCKED
  - Outputs: show_code=0, invert=0.
  - mic_trig → SHOW, and the timer loads 0.
  - All other inputs are ignored.
- SHOW
  - Outputs: show_code=1, invert=0.
  - Timer increments every cycle.
  - Timer == SHOW_CYC-1 or btn_next → ENTRY, with digit_idx=0 and all four entry digits cleared to 0.
- ENTRY
  - Outputs: show_code=0.
  - btn_up: current digit +1, wrapping 9→0.
  - btn_down: current digit -1, wrapping 0→9.
  - btn_up and btn_down in the same cycle: no change.
  - btn_next has priority over up/down in the same cycle; up/down are discarded that cycle.
  - btn_next with digit_idx<3: digit_idx+1.
  - btn_next with digit_idx==3: → CHECK.
  - mic_trig is ignored.
- CHECK (exactly one cycle)
  - Compare the 16-bit entry against CODE.
  - Match: fail_cnt←0, → UNLOCKED.
  - Mismatch: fail_cnt←fail_cnt+1. If the new value == MAX_TRIES, → LOCKOUT (see Configuration). Otherwise → LOCKED.
- UNLOCKED
  - Outputs: show_code=1, invert=1, unlocked=1.
  - lock → LOCKED.
  - Other inputs are ignored.
- LOCKOUT
  - Outputs: show_code=1, invert=timer[24], lockout=1.
  - All inputs are ignored.
  - Timer == LOCKOUT_CYC-1 → LOCKED, fail_cnt←0.
- digit_val always shows the entry register at digit_idx; it is meaningful in ENTRY only.
- Timer is 32 bits, shared by SHOW and LOCKOUT, and cleared on every state entry.

## Timing
- All outputs are registered. A state change caused by an input pulse in cycle N is visible on the outputs in cycle N+1.
- Reset values:
  - state LOCKED.
  - show_code=0, invert=0, unlocked=0, lockout=0.
  - digit_idx=0, digit_val=0, fail_cnt=0.
  - timer=0, entry=16'h0000.
- Reset is asynchronous and takes effect mid-operation in any state. There is no state retention.
- SHOW lasts exactly SHOW_CYC cycles with show_code=1 when not skipped.
- LOCKOUT lasts exactly LOCKOUT_CYC cycles.
- From the 4th btn_next to the UNLOCKED outputs: 2 cycles (CHECK plus the registered output).
- Input pulses longer than one cycle are counted once per high cycle; the front end guarantees single-cycle pulses.

## Configuration
- `PASSCODE_LOCKOUT_EN` defined:
  - LOCKOUT state present; behaviour as above.
- `PASSCODE_LOCKOUT_EN` undefined:
  - LOCKOUT state and its timer compare are not synthesised.
  - lockout is tied to 0.
  - A mismatch always → LOCKED.
  - fail_cnt saturates at MAX_TRIES and clears only on a successful match or reset.

## Test plan
All scenarios use SHOW_CYC=4, LOCKOUT_CYC=8, MAX_TRIES=3.
- Reset, then mic_trig: show_code=1 for exactly 4 cycles, then ENTRY with digit_idx=0 and digit_val=0.
- Enter 2,0,2,6 (two btn_up; next; next; two btn_up; next; six btn_up; next): unlocked=1 and invert=1 two cycles after the last next. lock → LOCKED, show_code=0.
- Digit wrap: btn_down at 0 gives digit_val=9; btn_up at 9 gives 0. btn_up with btn_down in the same cycle leaves the digit unchanged. btn_next with btn_up in the same cycle advances digit_idx without changing the digit.
- Three wrong entries (0000) with the macro defined: fail_cnt goes 1,2,3. lockout=1 for 8 cycles with mic_trig and buttons ignored, then LOCKED with fail_cnt=0.
- Same sequence without the macro: lockout stays 0, fail_cnt saturates at 3, and the next correct entry unlocks and clears fail_cnt.
- rst_n low mid-ENTRY and mid-LOCKOUT: all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/passcode_controller.sv
// Passcode screen sequencer: mic-triggered show, 4-digit BCD entry, code check, retry limit.
// Define PASSCODE_LOCKOUT_EN to build the timed LOCKOUT state; otherwise fail_cnt just saturates.
module passcode_controller #(
  parameter logic [15:0] CODE        = 16'h2026,
  parameter int          MAX_TRIES   = 3,
  parameter int          SHOW_CYC    = 100_000_000,
  parameter int          LOCKOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mic_trig,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       lock,
  output logic       show_code,
  output logic       invert,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] digit_idx,
  output logic [3:0] digit_val,
  output logic [3:0] fail_cnt
);

  if (MAX_TRIES < 1 || MAX_TRIES > 15 || SHOW_CYC < 1 || LOCKOUT_CYC < 1) begin : g_bad_cfg
    $error("passcode_controller: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_LOCKED,
    S_SHOW,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED
`ifdef PASSCODE_LOCKOUT_EN
    , S_LOCKOUT
`endif
  } state_t;

  localparam logic [31:0] SHOW_LAST = 32'(SHOW_CYC - 1);
  localparam logic [3:0]  MAX_FAIL  = 4'(MAX_TRIES);
`ifdef PASSCODE_LOCKOUT_EN
  localparam logic [31:0] LOCK_LAST = 32'(LOCKOUT_CYC - 1);
`endif

  state_t          state_q, state_d;
  logic [31:0]     timer_q, timer_d;
  logic [3:0][3:0] entry_q, entry_d;   // entry_q[3] is digit 0 (leftmost)
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      fail_q, fail_d;
  logic            show_q, show_d;
  logic            inv_q, inv_d;
  logic            unl_q, unl_d;
  logic [3:0]      val_q, val_d;

  logic [3:0] cur_digit, digit_inc, digit_dec, fail_inc;
  logic       cnt_en;

  assign cur_digit = entry_q[2'd3 - idx_q];
  assign digit_inc = (cur_digit >= 4'd9) ? 4'd0 : cur_digit + 4'd1;
  assign digit_dec = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
  assign fail_inc  = fail_q + 4'd1;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    case (state_q)
      S_LOCKED: if (mic_trig) state_d = S_SHOW;
      S_SHOW: begin
        if (timer_q == SHOW_LAST || btn_next) begin
          state_d = S_ENTRY;
          idx_d   = 2'd0;
          entry_d = '0;
        end
      end
      S_ENTRY: begin
        // next wins over up/down; up and down together cancel
        if (btn_next) begin
          if (idx_q == 2'd3) state_d = S_CHECK;
          else               idx_d   = idx_q + 2'd1;
        end else if (btn_up ^ btn_down) begin
          entry_d[2'd3 - idx_q] = btn_up ? digit_inc : digit_dec;
        end
      end
      S_CHECK: begin
        if (entry_q == CODE) begin
          fail_d  = 4'd0;
          state_d = S_UNLOCKED;
        end else begin
`ifdef PASSCODE_LOCKOUT_EN
          fail_d  = fail_inc;
          state_d = (fail_inc == MAX_FAIL) ? S_LOCKOUT : S_LOCKED;
`else
          if (fail_q < MAX_FAIL) fail_d = fail_inc;
          state_d = S_LOCKED;
`endif
        end
      end
      S_UNLOCKED: if (lock) state_d = S_LOCKED;
`ifdef PASSCODE_LOCKOUT_EN
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_LOCKED;
          fail_d  = 4'd0;
        end
      end
`endif
      default: state_d = S_LOCKED;
    endcase
  end

  // Shared timer: zero on every state entry, counts only in timed states.
`ifdef PASSCODE_LOCKOUT_EN
  assign cnt_en = (state_q == S_SHOW) || (state_q == S_LOCKOUT);
`else
  assign cnt_en = (state_q == S_SHOW);
`endif

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (cnt_en)        timer_d = timer_q + 32'd1;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    show_d = 1'b0;
    inv_d  = 1'b0;
    unl_d  = 1'b0;
    val_d  = entry_d[2'd3 - idx_d];
    case (state_d)
      S_SHOW:     show_d = 1'b1;
      S_UNLOCKED: begin
        show_d = 1'b1;
        inv_d  = 1'b1;
        unl_d  = 1'b1;
      end
`ifdef PASSCODE_LOCKOUT_EN
      S_LOCKOUT: begin
        show_d = 1'b1;
        inv_d  = timer_d[24];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      timer_q <= '0;
      entry_q <= '0;
      idx_q   <= '0;
      fail_q  <= '0;
      show_q  <= 1'b0;
      inv_q   <= 1'b0;
      unl_q   <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      entry_q <= entry_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      show_q  <= show_d;
      inv_q   <= inv_d;
      unl_q   <= unl_d;
      val_q   <= val_d;
    end
  end

`ifdef PASSCODE_LOCKOUT_EN
  logic lko_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lko_q <= 1'b0;
    else        lko_q <= (state_d == S_LOCKOUT);
  end
  assign lockout = lko_q;
`else
  assign lockout = 1'b0;
`endif

  assign show_code = show_q;
  assign invert    = inv_q;
  assign unlocked  = unl_q;
  assign digit_idx = idx_q;
  assign digit_val = val_q;
  assign fail_cnt  = fail_q;

endmodule
